// File: rtl/regfile_32x32_sync_pkg.sv
// Shared constants for the decode-stage integer register file.
package regfile_32x32_sync_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [0:REG_ADDR_W-1] REG_ZERO = 5'd0;

  typedef logic [0:WORD_W-1]     word_t;
  typedef logic [0:REG_ADDR_W-1] reg_addr_t;

  // True when the index names the hardwired-zero register
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_32x32_sync_if.sv
// Writeback/decode bundle for the register file: one write port, two
// read indices, the stall input and the two registered operand buses.
interface regfile_32x32_sync_if
  import regfile_32x32_sync_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) ();

  logic              we;
  logic [0:ADDR_W-1] wr_addr;
  logic [0:WIDTH-1]  wr_data;
  logic [0:ADDR_W-1] rd_addr_a;
  logic [0:ADDR_W-1] rd_addr_b;
  logic              hold;
  logic [0:WIDTH-1]  busA;
  logic [0:WIDTH-1]  busB;

  modport master (
    output we, wr_addr, wr_data, rd_addr_a, rd_addr_b, hold,
    input  busA, busB
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr_a, rd_addr_b, hold,
    output busA, busB
  );

endinterface

// File: rtl/mux2to1_32bit.sv
// Library 2:1 word multiplexer; sel=1 picks b.
module mux2to1_32bit
  import regfile_32x32_sync_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             sel,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic [0:WIDTH-1] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux32to1_32bit.sv
// Library 32:1 word multiplexer indexed by a register number.
module mux32to1_32bit
  import regfile_32x32_sync_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SEL_W = REG_ADDR_W
) (
  input  logic [0:WIDTH-1] din [2**SEL_W],
  input  logic [0:SEL_W-1] sel,
  output logic [0:WIDTH-1] dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regfile_read_port.sv
// One registered read port: array select, write-through bypass, R0 zero
// force, then the operand flop that doubles as the ID/EX register.
module regfile_read_port
  import regfile_32x32_sync_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:WIDTH-1]  regs [2**ADDR_W],
  input  logic [0:ADDR_W-1] rd_addr,
  input  logic              we,
  input  logic [0:ADDR_W-1] wr_addr,
  input  logic [0:WIDTH-1]  wr_data,
  input  logic              hold,
  output logic [0:WIDTH-1]  rd_data
);

  localparam logic [0:WIDTH-1] ZERO_WORD = '0;

  logic [0:WIDTH-1] array_word;
  logic [0:WIDTH-1] bypass_word;
  logic [0:WIDTH-1] next_word;
  logic             bypass_hit;
  logic             zero_hit;

  // A write to R0 never bypasses because the zero force sits last.
  assign bypass_hit = we && (wr_addr == rd_addr);
  assign zero_hit   = (rd_addr == '0);

  mux32to1_32bit #(.WIDTH(WIDTH), .SEL_W(ADDR_W)) u_array_mux (
    .din  (regs),
    .sel  (rd_addr),
    .dout (array_word)
  );

  mux2to1_32bit #(.WIDTH(WIDTH)) u_bypass_mux (
    .sel (bypass_hit),
    .a   (array_word),
    .b   (wr_data),
    .y   (bypass_word)
  );

  mux2to1_32bit #(.WIDTH(WIDTH)) u_zero_mux (
    .sel (zero_hit),
    .a   (bypass_word),
    .b   (ZERO_WORD),
    .y   (next_word)
  );

  // Capture the selected operand unless the pipeline is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!hold) begin
      rd_data <= next_word;
    end
  end

endmodule

// File: rtl/regfile_32x32_sync.sv
// 32x32 integer register file with R0 hardwired to zero, one write port
// and two registered read ports with same-cycle write-through.
module regfile_32x32_sync
  import regfile_32x32_sync_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_32x32_sync_if.slave  bus
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] wr_sel;
  logic [0:WIDTH-1] regs [NREGS];

  // One-hot write decode gated by we; the R0 line is tied low
  always_comb begin
    wr_sel = '0;
    if (bus.we) begin
      wr_sel[bus.wr_addr] = 1'b1;
    end
    wr_sel[0] = 1'b0;
  end

  // Register array: reset clears every entry and drops any same-cycle write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= bus.wr_data;
        end
      end
    end
  end

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .regs    (regs),
    .rd_addr (bus.rd_addr_a),
    .we      (bus.we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .hold    (bus.hold),
    .rd_data (bus.busA)
  );

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .regs    (regs),
    .rd_addr (bus.rd_addr_b),
    .we      (bus.we),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .hold    (bus.hold),
    .rd_data (bus.busB)
  );

endmodule

// File: tb/tb_regfile_32x32_sync.sv
// Directed self-checking bench for regfile_32x32_sync.
module tb_regfile_32x32_sync;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_32x32_sync_if bus ();

  regfile_32x32_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic hold);
    bus.we        = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    bus.hold      = hold;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: busA=%h busB=%h expected 00000000", bus.busA, bus.busB);
    end
    rst_n = 1'b1;
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 1'b0);
      tick();
      checks++;
      if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d: busA=%h busB=%h expected 00000000", a, bus.busA, bus.busB);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd6, 32'h0F0F1234, 5'd5, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_read_r5: busA=%h expected deadbeef", bus.busA);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd5, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0F0F1234 || bus.busB !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_read_r6_r5: busA=%h busB=%h expected 0f0f1234 deadbeef",
               bus.busA, bus.busB);
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL r0_write_edge: busA=%h busB=%h expected 00000000", bus.busA, bus.busB);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL r0_later_read: busA=%h busB=%h expected 00000000", bus.busA, bus.busB);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h12345678 || bus.busB !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL bypass_same_edge: busA=%h busB=%h expected 12345678", bus.busA, bus.busB);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h12345678 || bus.busB !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL bypass_next_cycle: busA=%h busB=%h expected 12345678", bus.busA, bus.busB);
    end
    // Bypass on A only, B reads an unrelated register from the array
    drive(1'b1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd5, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'hA5A5A5A5 || bus.busB !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_port_a_only: busA=%h busB=%h expected a5a5a5a5 deadbeef",
               bus.busA, bus.busB);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 5'd3, 32'h0000AAAA, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0000AAAA || bus.busB !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL hold_setup: busA=%h busB=%h expected 0000aaaa 12345678", bus.busA, bus.busB);
    end
    drive(1'b1, 5'd3, 32'h0000BBBB, 5'd3, 5'd5, 1'b1);
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (bus.busA !== 32'h0000AAAA || bus.busB !== 32'h12345678) begin
        errors++;
        $display("[TB] FAIL hold_edge%0d: busA=%h busB=%h expected 0000aaaa 12345678",
                 e, bus.busA, bus.busB);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0000BBBB || bus.busB !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL hold_release: busA=%h busB=%h expected 0000bbbb deadbeef", bus.busA, bus.busB);
    end
  endtask

  task automatic test_reset_mid_write();
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd3, 1'b1);
    tick();
    checks++;
    if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_overrides_hold: busA=%h busB=%h expected 00000000", bus.busA, bus.busB);
    end
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 1'b0);
    tick();
    checks++;
    if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_write_r9: busA=%h busB=%h expected 00000000", bus.busA, bus.busB);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_hold();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
